// File: rtl/ticket_vend_ctrl.sv
// ticket_vend_ctrl: multi-destination ticket vending controller.
// Accumulates coin credit for a selected destination, issues a one-hot
// ticket pulse plus change once the price is reached, and refunds on
// cancel or inactivity timeout. Coins that cannot be accepted are returned.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   sel_valid, sel    destination select strobe, 1..NUM_DEST
//   coin_valid, coin  coin strobe, code 01=5 10=10 11=20 00=invalid
//   cancel            refund request
//   credit            accumulated credit (registered)
//   busy              high while not IDLE
//   coin_reject       one-cycle pulse, previous coin returned
//   vend              one-hot one-cycle ticket pulse
//   change_valid      one-cycle pulse qualifying change
//   change            change / refund amount, 0 when change_valid low
module ticket_vend_ctrl #(
    parameter int NUM_DEST   = 3,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 6,
    parameter logic [NUM_DEST*CREDIT_W-1:0] PRICES = {6'd15, 6'd10, 6'd5},
    parameter int MAX_CREDIT = 40,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic [NUM_DEST-1:0] vend,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change
);

    // Keep at least one timer bit so TIMEOUT=0 (disabled) still elaborates.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    state_t              state_q;
    logic [SEL_W-1:0]    dest_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [TW-1:0]       timer_q;
    logic                busy_q;
    logic                coin_reject_q;
    logic [NUM_DEST-1:0] vend_q;
    logic                change_valid_q;
    logic [CREDIT_W-1:0] change_q;

    function automatic logic [CREDIT_W:0] coin_val(input logic [1:0] c);
        case (c)
            2'b01:   return (CREDIT_W+1)'(5);
            2'b10:   return (CREDIT_W+1)'(10);
            2'b11:   return (CREDIT_W+1)'(20);
            default: return '0;
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] d);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_DEST; i++)
            if (d == SEL_W'(i + 1)) p = PRICES[i*CREDIT_W +: CREDIT_W];
        return p;
    endfunction

    logic                sel_ok;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   sum;      // one extra bit so the ceiling check cannot wrap
    logic                coin_bad;
    logic                tmo_hit;

    always_comb begin
        sel_ok   = (sel != '0) && (sel <= SEL_W'(NUM_DEST));
        price    = price_of(dest_q);
        sum      = {1'b0, credit_q} + coin_val(coin);
        coin_bad = (coin == 2'b00) || (sum > (CREDIT_W+1)'(MAX_CREDIT));
        tmo_hit  = (TIMEOUT != 0) && (timer_q == TMO_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            dest_q         <= '0;
            credit_q       <= '0;
            timer_q        <= '0;
            busy_q         <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_q         <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            coin_reject_q  <= 1'b0;
            vend_q         <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (coin_valid) coin_reject_q <= 1'b1;
                    if (sel_valid && sel_ok) begin
                        dest_q  <= sel;
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (cancel || tmo_hit) begin
                        state_q <= REFUND;
                        timer_q <= '0;
                        if (coin_valid) coin_reject_q <= 1'b1;
                    end else if (coin_valid && coin_bad) begin
                        coin_reject_q <= 1'b1;
                        if (timer_q != '1) timer_q <= timer_q + 1'b1;
                    end else if (coin_valid) begin
                        credit_q <= sum[CREDIT_W-1:0];
                        timer_q  <= '0;
                        if (sum >= {1'b0, price}) state_q <= VEND;
                    end else begin
                        if (timer_q != '1) timer_q <= timer_q + 1'b1;
                    end
                end
                VEND: begin
                    vend_q         <= NUM_DEST'(1) << (dest_q - 1'b1);
                    change_valid_q <= 1'b1;
                    change_q       <= credit_q - price;
                    credit_q       <= '0;
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    if (coin_valid) coin_reject_q <= 1'b1;
                end
                REFUND: begin
                    change_valid_q <= (credit_q != '0);
                    change_q       <= credit_q;
                    credit_q       <= '0;
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    if (coin_valid) coin_reject_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign credit       = credit_q;
    assign busy         = busy_q;
    assign coin_reject  = coin_reject_q;
    assign vend         = vend_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Directed bench for ticket_vend_ctrl with MAX_CREDIT=20, TIMEOUT=8.
// Prices: dest1=5, dest2=10, dest3=15.
module tb_ticket_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_valid;
    logic [1:0] sel;
    logic       coin_valid;
    logic [1:0] coin;
    logic       cancel;
    logic [5:0] credit;
    logic       busy;
    logic       coin_reject;
    logic [2:0] vend;
    logic       change_valid;
    logic [5:0] change;

    int total  = 0;
    int passed = 0;

    ticket_vend_ctrl #(.MAX_CREDIT(20), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel(sel),
        .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
        .credit(credit), .busy(busy), .coin_reject(coin_reject), .vend(vend),
        .change_valid(change_valid), .change(change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge; sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sel_valid = 0; coin_valid = 0; cancel = 0; coin = 2'b00;
    endtask

    task automatic do_sel(input logic [1:0] s);
        sel_valid = 1; sel = s; tick(); idle_in();
    endtask

    task automatic do_coin(input logic [1:0] c);
        coin_valid = 1; coin = c; tick(); idle_in();
    endtask

    // Check the full output set in one call.
    task automatic outs(input string tag, input logic [5:0] cr, input logic b,
                        input logic rj, input logic [2:0] v, input logic cv,
                        input logic [5:0] ch);
        chk({tag, ".credit"}, 32'(credit), 32'(cr));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".reject"}, 32'(coin_reject), 32'(rj));
        chk({tag, ".vend"}, 32'(vend), 32'(v));
        chk({tag, ".cvalid"}, 32'(change_valid), 32'(cv));
        chk({tag, ".change"}, 32'(change), 32'(ch));
    endtask

    initial begin
        idle_in(); sel = 0; rst = 0;
        #12;
        outs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1;
        tick();

        // sel=1 price 5, single coin 5 -> change 0 still flagged
        do_sel(2'd1);
        outs("t1.sel", 0, 1, 0, 0, 0, 0);
        do_coin(2'b01);
        outs("t1.coin", 5, 1, 0, 0, 0, 0);
        tick();
        outs("t1.vend", 0, 0, 0, 3'b001, 1, 0);
        tick();
        outs("t1.after", 0, 0, 0, 0, 0, 0);

        // sel=3 price 15, coins 10+10 -> change 5
        do_sel(2'd3);
        do_coin(2'b10);
        chk("t2.credit10", 32'(credit), 10);
        do_coin(2'b10);
        chk("t2.credit20", 32'(credit), 20);
        tick();
        outs("t2.vend", 0, 0, 0, 3'b100, 1, 5);

        // sel=2 price 10, coin 20, second coin during VEND rejected
        do_sel(2'd2);
        do_coin(2'b11);
        chk("t3.credit", 32'(credit), 20);
        do_coin(2'b11);
        outs("t3.vend", 0, 0, 1, 3'b010, 1, 10);
        tick();
        outs("t3.idle", 0, 0, 0, 0, 0, 0);

        // cancel together with a coin: coin rejected, refund 5
        do_sel(2'd3);
        do_coin(2'b01);
        cancel = 1; coin_valid = 1; coin = 2'b10; tick(); idle_in();
        outs("t4.cancel", 5, 1, 1, 0, 0, 0);
        tick();
        outs("t4.refund", 0, 0, 0, 0, 1, 5);

        // timeout: 8 idle edges then REFUND, change on the 9th
        do_sel(2'd3);
        do_coin(2'b01);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5.wait_cv", 32'(change_valid), 0);
            chk("t5.wait_busy", 32'(busy), 1);
        end
        tick();
        outs("t5.timeout", 0, 0, 0, 0, 1, 5);

        // cancel with zero credit: no change pulse
        do_sel(2'd3);
        cancel = 1; tick(); idle_in();
        chk("t5b.busy_refund", 32'(busy), 1);
        tick();
        outs("t5b.nochange", 0, 0, 0, 0, 0, 0);

        // ceiling: 5+5 then 20 would be 30 > 20 -> rejected, then 5 vends
        do_sel(2'd3);
        do_coin(2'b01);
        do_coin(2'b01);
        do_coin(2'b11);
        outs("t6.reject", 10, 1, 1, 0, 0, 0);
        do_coin(2'b01);
        outs("t6.credit15", 15, 1, 0, 0, 0, 0);
        tick();
        outs("t6.vend", 0, 0, 0, 3'b100, 1, 0);

        // coin in IDLE is rejected, credit untouched
        do_coin(2'b10);
        outs("t7.idle_coin", 0, 0, 1, 0, 0, 0);

        // invalid selection ignored
        do_sel(2'd0);
        chk("t8.sel0_busy", 32'(busy), 0);

        // simultaneous sel and coin in IDLE: sel taken, coin rejected
        sel_valid = 1; sel = 2'd3; coin_valid = 1; coin = 2'b10; tick(); idle_in();
        outs("t9.simul", 0, 1, 1, 0, 0, 0);

        // invalid coin code 00 in COLLECT
        do_coin(2'b00);
        outs("t10.code00", 0, 1, 1, 0, 0, 0);
        do_coin(2'b10);
        chk("t10.credit", 32'(credit), 10);

        // async reset mid-COLLECT clears everything without waiting for a clock
        #2 rst = 0;
        #1;
        outs("t11.async_rst", 0, 0, 0, 0, 0, 0);
        #3 rst = 1;
        tick();
        outs("t11.post_rst", 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
